// File: rtl/clause_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clause_fifo_pkg
// Description : Shared constants, clause word type and width helpers for the
//               clause_fifo_tree collector and its compactor.
// Revision    : 1.0 - initial release
// ============================================================================
package clause_fifo_pkg;

    localparam int CLAUSE_COUNT_DEF = 20;
    localparam int CLAUSE_WIDTH_DEF = 36;
    localparam int BUFFER_DEPTH_DEF = 32;

    typedef logic [CLAUSE_WIDTH_DEF-1:0] clause_t;

    // Pointer width: indexes BUFFER_DEPTH entries and wraps naturally.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so that "full" (== depth) is representable.
    function automatic int count_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    // Width able to hold any lane popcount 0..lanes.
    function automatic int lane_count_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage : clause_fifo_pkg
`default_nettype wire

// File: rtl/clause_compactor.sv
`default_nettype none
// ============================================================================
// Module      : clause_compactor
// Description : Combinational exclusive prefix-popcount over the lane valid
//               vector. Lane k's write offset is the number of valid lanes
//               below it; n_valid is the total.
// Ports       : valid   - per-lane valid bits (already qualified by wren)
//               offsets - packed per-lane offsets, lane k at [k*OFF_W +: OFF_W]
//               n_valid - popcount of valid
// Revision    : 1.0 - initial release
// ============================================================================
module clause_compactor
    import clause_fifo_pkg::*;
#(
    parameter int CLAUSE_COUNT = CLAUSE_COUNT_DEF,
    parameter int OFF_W        = lane_count_width(CLAUSE_COUNT)
) (
    input  logic [CLAUSE_COUNT-1:0]       valid,
    output logic [CLAUSE_COUNT*OFF_W-1:0] offsets,
    output logic [OFF_W-1:0]              n_valid
);

    logic [OFF_W-1:0] prefix [CLAUSE_COUNT];

    // Kogge-Stone style inclusive prefix sum: each pass doubles the span.
    // Walking k downwards lets the update happen in place while still
    // reading the previous pass's value at k-step.
    always_comb begin
        for (int k = 0; k < CLAUSE_COUNT; k++) begin
            prefix[k] = OFF_W'(valid[k]);
        end
        for (int step = 1; step < CLAUSE_COUNT; step = step * 2) begin
            for (int k = CLAUSE_COUNT - 1; k >= step; k--) begin
                prefix[k] = prefix[k] + prefix[k-step];
            end
        end
    end

    always_comb begin
        offsets = '0;
        for (int k = 0; k < CLAUSE_COUNT; k++) begin
            offsets[k*OFF_W +: OFF_W] = prefix[k] - OFF_W'(valid[k]);
        end
        n_valid = prefix[CLAUSE_COUNT-1];
    end

endmodule : clause_compactor
`default_nettype wire

// File: rtl/clause_fifo_tree.sv
`default_nettype none
// ============================================================================
// Module      : clause_fifo_tree
// Description : Multi-write, single-read clause collector. Valid lanes are
//               compacted in ascending lane order into a shared circular
//               buffer; one entry is popped per cycle (first-word
//               fall-through). Dropped clauses set a sticky overflow flag.
// Ports       : clk, reset (async, active-low)
//               clauses_i/clause_valid_i/wren - lane write interface
//               rden - pop head; cOF - clear overflow flag
//               empty, OF, clause_o - status and head entry
// Revision    : 1.0 - initial release
// ============================================================================
module clause_fifo_tree
    import clause_fifo_pkg::*;
#(
    parameter int CLAUSE_COUNT = CLAUSE_COUNT_DEF,
    parameter int CLAUSE_WIDTH = CLAUSE_WIDTH_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] clauses_i,
    input  logic [CLAUSE_COUNT-1:0]          clause_valid_i,
    input  logic                             wren,
    input  logic                             rden,
    input  logic                             cOF,
    output logic                             empty,
    output logic                             OF,
    output logic [CLAUSE_WIDTH-1:0]          clause_o
);

    localparam int PTR_W = ptr_width(BUFFER_DEPTH);
    localparam int CNT_W = count_width(BUFFER_DEPTH);
    localparam int OFF_W = lane_count_width(CLAUSE_COUNT);

    logic [CLAUSE_WIDTH-1:0]       mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              count;
    logic                          of_flag;

    logic [CLAUSE_COUNT-1:0]       lane_valid;
    logic [CLAUSE_COUNT*OFF_W-1:0] offsets;
    logic [OFF_W-1:0]              n_valid;
    logic [CNT_W-1:0]              n_valid_ext;
    logic [CNT_W-1:0]              free_slots;
    logic [CNT_W-1:0]              n_wr;
    logic                          overflow;
    logic                          pop;
    logic [CLAUSE_COUNT-1:0]       lane_we;
    logic [PTR_W-1:0]              lane_addr [CLAUSE_COUNT];

    assign lane_valid = wren ? clause_valid_i : '0;

    clause_compactor #(
        .CLAUSE_COUNT (CLAUSE_COUNT),
        .OFF_W        (OFF_W)
    ) u_compactor (
        .valid   (lane_valid),
        .offsets (offsets),
        .n_valid (n_valid)
    );

    // Space is judged on the pre-pop occupancy: a same-cycle pop frees nothing.
    assign n_valid_ext = CNT_W'(n_valid);
    assign free_slots  = CNT_W'(BUFFER_DEPTH) - count;
    assign overflow    = (n_valid_ext > free_slots);
    assign n_wr        = overflow ? free_slots : n_valid_ext;
    assign pop         = rden && (count != '0);

    // Lanes whose offset lies beyond the free space are the ones dropped;
    // because offsets ascend with lane index, the lowest lanes always win.
    always_comb begin
        for (int k = 0; k < CLAUSE_COUNT; k++) begin
            lane_we[k]   = lane_valid[k] && (CNT_W'(offsets[k*OFF_W +: OFF_W]) < n_wr);
            lane_addr[k] = wr_ptr + PTR_W'(offsets[k*OFF_W +: OFF_W]);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CLAUSE_COUNT; k++) begin
            if (lane_we[k]) begin
                mem[lane_addr[k]] <= clauses_i[k*CLAUSE_WIDTH +: CLAUSE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            of_flag <= 1'b0;
        end else begin
            // Truncation to PTR_W gives the modulo-depth wrap.
            wr_ptr <= wr_ptr + PTR_W'(n_wr);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + n_wr - CNT_W'(pop);
            if (overflow) begin
                of_flag <= 1'b1;
            end else if (cOF) begin
                of_flag <= 1'b0;
            end
        end
    end

    assign empty    = (count == '0);
    assign OF       = of_flag;
    assign clause_o = empty ? '0 : mem[rd_ptr];

endmodule : clause_fifo_tree
`default_nettype wire

// File: tb/tb_clause_fifo_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_clause_fifo_tree
// Description : Directed, table-driven bench for clause_fifo_tree. Lane k of
//               a write tagged "base" carries the word (base << 8) | k, so
//               every expected head value is known by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clause_fifo_tree;
    import clause_fifo_pkg::*;

    localparam int NL = 20;
    localparam int W  = 36;
    localparam int D  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [W*NL-1:0]   clauses_i;
    logic [NL-1:0]     clause_valid_i;
    logic              wren, rden, cOF;
    logic              empty, OF;
    logic [W-1:0]      clause_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clause_fifo_tree #(
        .CLAUSE_COUNT (NL),
        .CLAUSE_WIDTH (W),
        .BUFFER_DEPTH (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clauses_i      (clauses_i),
        .clause_valid_i (clause_valid_i),
        .wren           (wren),
        .rden           (rden),
        .cOF            (cOF),
        .empty          (empty),
        .OF             (OF),
        .clause_o       (clause_o)
    );

    typedef struct {
        logic          w;
        logic [NL-1:0] v;
        logic [7:0]    base;
        logic          r;
        logic          c;
        logic          e_empty;
        logic          e_of;
        logic [W-1:0]  e_clause;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic w, input logic [NL-1:0] v, input logic [7:0] base,
                                input logic r, input logic c, input logic e_empty,
                                input logic e_of, input logic [W-1:0] e_clause);
        vec_t t;
        t.w = w; t.v = v; t.base = base; t.r = r; t.c = c;
        t.e_empty = e_empty; t.e_of = e_of; t.e_clause = e_clause;
        return t;
    endfunction

    function automatic logic [W-1:0] lane_word(input logic [7:0] base, input int k);
        return W'((int'(base) << 8) | k);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [NL-1:0] v, input logic [7:0] base,
                         input logic r, input logic c);
        wren = w; clause_valid_i = v; rden = r; cOF = c;
        for (int k = 0; k < NL; k++) clauses_i[k*W +: W] = lane_word(base, k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pops(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 8'h00, 1'b1, 1'b0);
    endtask

    logic [W-1:0] exp_q [$];

    initial begin
        reset = 1'b0; wren = 1'b0; rden = 1'b0; cOF = 1'b0;
        clause_valid_i = '0; clauses_i = '0;

        tbl[0]  = mk(0, 20'h00000, 8'h00, 1, 0, 1, 0, 36'h0);
        tbl[1]  = mk(1, 20'h00025, 8'h01, 0, 0, 0, 0, 36'h100);
        tbl[2]  = mk(0, 20'h00000, 8'h00, 1, 0, 0, 0, 36'h102);
        tbl[3]  = mk(0, 20'h00000, 8'h00, 1, 0, 0, 0, 36'h105);
        tbl[4]  = mk(0, 20'h00000, 8'h00, 1, 0, 1, 0, 36'h0);
        tbl[5]  = mk(1, 20'h00088, 8'h02, 0, 0, 0, 0, 36'h203);
        tbl[6]  = mk(1, 20'h80002, 8'h03, 0, 0, 0, 0, 36'h203);
        tbl[7]  = mk(0, 20'h00000, 8'h00, 1, 0, 0, 0, 36'h207);
        tbl[8]  = mk(0, 20'h00000, 8'h00, 1, 0, 0, 0, 36'h301);
        tbl[9]  = mk(0, 20'h00000, 8'h00, 1, 0, 0, 0, 36'h313);
        tbl[10] = mk(0, 20'h00000, 8'h00, 1, 0, 1, 0, 36'h0);
        tbl[11] = mk(1, 20'hFFFFF, 8'h04, 0, 0, 0, 0, 36'h400);
        tbl[12] = mk(1, 20'h003FF, 8'h05, 0, 0, 0, 0, 36'h400);
        tbl[13] = mk(1, 20'h00FFF, 8'h06, 0, 0, 0, 1, 36'h400);
        tbl[14] = mk(0, 20'h00000, 8'h00, 0, 1, 0, 0, 36'h400);
        tbl[15] = mk(1, 20'h00001, 8'h07, 0, 1, 0, 1, 36'h400);
        tbl[16] = mk(1, 20'h00001, 8'h08, 1, 0, 0, 1, 36'h401);
        tbl[17] = mk(0, 20'h00000, 8'h00, 0, 1, 0, 0, 36'h401);

        #12;
        check("reset_empty", W'(empty), W'(1'b1));
        check("reset_of", W'(OF), W'(1'b0));
        check("reset_clause", clause_o, '0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].w, tbl[i].v, tbl[i].base, tbl[i].r, tbl[i].c);
            check($sformatf("vec%0d_empty", i), W'(empty), W'(tbl[i].e_empty));
            check($sformatf("vec%0d_of", i), W'(OF), W'(tbl[i].e_of));
            check($sformatf("vec%0d_clause", i), clause_o, tbl[i].e_clause);
        end

        // 31 entries remain: lanes 1..19 of tag 4, lanes 0..9 of tag 5,
        // lanes 0..1 of tag 6. Dropped writes (tags 7, 8) must not appear.
        for (int k = 1; k < 20; k++) exp_q.push_back(lane_word(8'h04, k));
        for (int k = 0; k < 10; k++) exp_q.push_back(lane_word(8'h05, k));
        for (int k = 0; k < 2; k++)  exp_q.push_back(lane_word(8'h06, k));
        for (int i = 1; i < 31; i++) begin
            idle_pops(1);
            check($sformatf("drain%0d", i), clause_o, exp_q[i]);
        end
        idle_pops(1);
        check("drain_empty", W'(empty), W'(1'b1));
        check("drain_clause", clause_o, '0);

        // Pointers sit at 7; move both to 30 (23 more entries).
        drive(1'b1, 20'hFFFFF, 8'h09, 1'b0, 1'b0);
        idle_pops(20);
        drive(1'b1, 20'h00007, 8'h0A, 1'b0, 1'b0);
        idle_pops(3);
        check("wrap_pre_empty", W'(empty), W'(1'b1));

        // Five entries into slots 30, 31, 0, 1, 2.
        drive(1'b1, 20'h0001F, 8'h0B, 1'b0, 1'b0);
        check("wrap_head0", clause_o, lane_word(8'h0B, 0));
        for (int k = 1; k < 5; k++) begin
            idle_pops(1);
            check($sformatf("wrap_head%0d", k), clause_o, lane_word(8'h0B, k));
        end
        idle_pops(1);
        check("wrap_empty", W'(empty), W'(1'b1));

        // Fill and overflow, then reset asynchronously between edges.
        drive(1'b1, 20'hFFFFF, 8'h0C, 1'b0, 1'b0);
        drive(1'b1, 20'hFFFFF, 8'h0D, 1'b0, 1'b0);
        check("pre_reset_of", W'(OF), W'(1'b1));
        check("pre_reset_head", clause_o, lane_word(8'h0C, 0));
        drive(1'b0, '0, 8'h00, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_empty", W'(empty), W'(1'b1));
        check("async_reset_of", W'(OF), W'(1'b0));
        check("async_reset_clause", clause_o, '0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, 8'h00, 1'b1, 1'b0);
        check("post_reset_empty", W'(empty), W'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clause_fifo_tree
`default_nettype wire
